// File: rtl/cdb_multi_arb.sv
// cdb_multi_arb: N-source, M-port common data bus arbiter with one holding buffer per source.
// Optional macro CDB_STARVE_EN adds per-buffer wait counters that promote long-waiting entries.
package cdb_pkg;
  localparam int ROB_W   = 6;
  localparam int EPOCH_W = 2;

  typedef struct packed {
    logic [ROB_W-1:0]   rob_idx;
    logic [EPOCH_W-1:0] epoch;
    logic [31:0]        data;
    logic               is_branch;
    logic               mispredict;
    logic               is_load;
    logic               is_store;
  } fu_wb_t;
endpackage

module cdb_multi_arb
  import cdb_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int N_PORTS      = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SRC-1:0]             src_valid,
  output logic [N_SRC-1:0]             src_ready,
  input  fu_wb_t [N_SRC-1:0]           src_pkt,
  input  logic                         flush_valid,
  input  logic [EPOCH_W-1:0]           flush_epoch,
  output logic [N_PORTS-1:0]           wb_valid,
  input  logic [N_PORTS-1:0]           wb_ready,
  output fu_wb_t [N_PORTS-1:0]         wb_pkt,
  output logic [$clog2(N_SRC+1)-1:0]   occ
);

  localparam int OCC_W = $clog2(N_SRC + 1);
  localparam int PTR_W = $clog2(N_SRC);

  if (N_PORTS < 1 || N_PORTS > N_SRC || N_SRC < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("cdb_multi_arb: invalid parameter combination");
  end

  // Handshakes: a source transfers on src_valid && src_ready at posedge; a port transfers
  // on wb_valid && wb_ready at posedge. Neither ready may depend on the matching valid.

  logic [N_SRC-1:0]   buf_v_q, buf_v_d;
  fu_wb_t [N_SRC-1:0] buf_q, buf_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic [N_SRC-1:0]   stale_buf, stale_in, elig, starving, gnt, drain, load;
  logic [N_PORTS-1:0] port_v;
  logic [PTR_W-1:0]   port_src [N_PORTS];

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      stale_buf[i] = flush_valid && (buf_q[i].epoch != flush_epoch);
      stale_in[i]  = flush_valid && (src_pkt[i].epoch != flush_epoch);
    end
    elig = buf_v_q & ~stale_buf;
  end

`ifdef CDB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [N_SRC-1:0][CNT_W-1:0] wait_q, wait_d;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      starving[i] = elig[i] && (wait_q[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  always_comb begin
    wait_d = wait_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (load[i] || drain[i] || !buf_v_d[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != CNT_W'(STARVE_LIMIT)) begin
        wait_d[i] = wait_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign starving = '0;
`endif

  // Priority: starving entries (lowest index first), then buffer 0, then RR from rr_ptr.
  always_comb begin
    int np;
    int idx;
    np     = 0;
    idx    = 0;
    gnt    = '0;
    port_v = '0;
    for (int k = 0; k < N_PORTS; k++) port_src[k] = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (starving[i] && np < N_PORTS) begin
        port_v[np]   = 1'b1;
        port_src[np] = PTR_W'(i);
        gnt[i]       = 1'b1;
        np           = np + 1;
      end
    end
    if (elig[0] && !gnt[0] && np < N_PORTS) begin
      port_v[np]   = 1'b1;
      port_src[np] = '0;
      gnt[0]       = 1'b1;
      np           = np + 1;
    end
    for (int j = 0; j < N_SRC - 1; j++) begin
      idx = int'(rr_ptr_q) + j;
      if (idx >= N_SRC) idx = idx - (N_SRC - 1);
      if (elig[idx] && !gnt[idx] && np < N_PORTS) begin
        port_v[np]   = 1'b1;
        port_src[np] = PTR_W'(idx);
        gnt[idx]     = 1'b1;
        np           = np + 1;
      end
    end
  end

  always_comb begin
    drain = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (port_v[k] && wb_ready[k]) drain[port_src[k]] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < N_PORTS; k++) begin
      wb_pkt[k] = port_v[k] ? buf_q[port_src[k]] : '0;
    end
  end
  assign wb_valid = port_v;

  // Pointer moves past the last RR source drained, scanning in RR order; 0 is never a target.
  always_comb begin
    int idx;
    idx      = 0;
    rr_ptr_d = rr_ptr_q;
    for (int j = 0; j < N_SRC - 1; j++) begin
      idx = int'(rr_ptr_q) + j;
      if (idx >= N_SRC) idx = idx - (N_SRC - 1);
      if (drain[idx]) rr_ptr_d = (idx == N_SRC - 1) ? PTR_W'(1) : PTR_W'(idx + 1);
    end
  end

  // A stale incoming packet is acknowledged but never written into the buffer.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = !rst && (!buf_v_q[i] || drain[i] || stale_buf[i] || stale_in[i]);
      load[i]      = src_valid[i] && src_ready[i] && !stale_in[i];
      buf_v_d[i]   = load[i] || (buf_v_q[i] && !drain[i] && !stale_buf[i]);
      buf_d[i]     = load[i] ? src_pkt[i] : buf_q[i];
      occ_d        = occ_d + OCC_W'(buf_v_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v_q  <= '0;
      buf_q    <= '0;
      rr_ptr_q <= PTR_W'(1);
      occ_q    <= '0;
    end else begin
      buf_v_q  <= buf_v_d;
      buf_q    <= buf_d;
      rr_ptr_q <= rr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ = occ_q;

endmodule

// File: tb/tb_cdb_multi_arb.sv
// Bench for cdb_multi_arb: a 2-port instance (dut) and a 1-port, STARVE_LIMIT=4 instance (dut_b),
// each checked by an in-order packet scoreboard plus per-scenario inline checks.
module tb_cdb_multi_arb;
  import cdb_pkg::*;

  localparam int PKT_W = $bits(fu_wb_t);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0]         src_valid;
  logic [3:0]         src_ready;
  fu_wb_t [3:0]       src_pkt;
  logic               flush_valid;
  logic [EPOCH_W-1:0] flush_epoch;
  logic [1:0]         wb_valid;
  logic [1:0]         wb_ready;
  fu_wb_t [1:0]       wb_pkt;
  logic [2:0]         occ;

  logic [3:0]         b_src_valid;
  logic [3:0]         b_src_ready;
  fu_wb_t [3:0]       b_src_pkt;
  logic               b_flush_valid;
  logic [EPOCH_W-1:0] b_flush_epoch;
  logic [0:0]         b_wb_valid;
  logic [0:0]         b_wb_ready;
  fu_wb_t [0:0]       b_wb_pkt;
  logic [2:0]         b_occ;

  int checks = 0;
  int errors = 0;

  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] exp_q_b[$];
  logic [PKT_W-1:0] sb_e;

  cdb_multi_arb #(.N_SRC(4), .N_PORTS(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_pkt(src_pkt),
    .flush_valid(flush_valid), .flush_epoch(flush_epoch),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pkt(wb_pkt),
    .occ(occ)
  );

  cdb_multi_arb #(.N_SRC(4), .N_PORTS(1), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .src_valid(b_src_valid), .src_ready(b_src_ready), .src_pkt(b_src_pkt),
    .flush_valid(b_flush_valid), .flush_epoch(b_flush_epoch),
    .wb_valid(b_wb_valid), .wb_ready(b_wb_ready), .wb_pkt(b_wb_pkt),
    .occ(b_occ)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every accepted writeback beat must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (wb_valid[k] && wb_ready[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_a_port%0d: got pkt %h, expected none", k, wb_pkt[k]);
          end else begin
            sb_e = exp_q.pop_front();
            if (wb_pkt[k] !== sb_e) begin
              errors++;
              $display("FAIL sb_a_port%0d: got %h exp %h", k, wb_pkt[k], sb_e);
            end
          end
        end
      end
      if (b_wb_valid[0] && b_wb_ready[0]) begin
        checks++;
        if (exp_q_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_port0: got pkt %h, expected none", b_wb_pkt[0]);
        end else begin
          sb_e = exp_q_b.pop_front();
          if (b_wb_pkt[0] !== sb_e) begin
            errors++;
            $display("FAIL sb_b_port0: got %h exp %h", b_wb_pkt[0], sb_e);
          end
        end
      end
    end
  end

  // driver helpers
  function automatic fu_wb_t mk_pkt(input logic [EPOCH_W-1:0] ep);
    fu_wb_t p;
    p            = '0;
    p.rob_idx    = ROB_W'($urandom_range(0, 63));
    p.epoch      = ep;
    p.data       = $urandom;
    p.is_branch  = 1'($urandom_range(0, 1));
    p.is_load    = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = 4'hF;
    b_src_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      src_pkt[i] = mk_pkt(0);
      b_src_pkt[i] = mk_pkt(0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (src_ready !== 4'h0) begin errors++; $display("FAIL reset_src_ready: got %h exp 0", src_ready); end
    checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL reset_wb_valid: got %b exp 00", wb_valid); end
    checks++; if (wb_pkt !== '0) begin errors++; $display("FAIL reset_wb_pkt: got %h exp 0", wb_pkt); end
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", occ); end
    checks++; if (b_src_ready !== 4'h0) begin errors++; $display("FAIL reset_b_src_ready: got %h exp 0", b_src_ready); end
    drive_slot();
    rst = 1'b0;
    src_valid = 4'h0;
    b_src_valid = 4'h0;
    @(negedge clk);
    checks++; if (src_ready !== 4'hF) begin errors++; $display("FAIL release_src_ready: got %h exp F", src_ready); end
    checks++; if (b_src_ready !== 4'hF) begin errors++; $display("FAIL release_b_src_ready: got %h exp F", b_src_ready); end
    checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL reset_rr_ptr: got %0d exp 1", dut.rr_ptr_q); end
  endtask

  task automatic test_drain_all();
    fu_wb_t pa [4];
    drive_slot();
    for (int i = 0; i < 4; i++) begin
      pa[i] = mk_pkt(0);
      src_pkt[i] = pa[i];
      exp_q.push_back(pa[i]);
    end
    src_valid = 4'hF;
    wb_ready = 2'b11;
    @(negedge clk);
    checks++; if (src_ready !== 4'hF) begin errors++; $display("FAIL drain_load_ready: got %h exp F", src_ready); end
    checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL drain_no_passthru: got %b exp 00", wb_valid); end
    drive_slot();
    src_valid = 4'h0;
    @(negedge clk);
    checks++; if (occ !== 3'd4) begin errors++; $display("FAIL drain_occ_c1: got %0d exp 4", occ); end
    checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL drain_valid_c1: got %b exp 11", wb_valid); end
    @(negedge clk);
    checks++; if (occ !== 3'd2) begin errors++; $display("FAIL drain_occ_c2: got %0d exp 2", occ); end
    checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL drain_valid_c2: got %b exp 11", wb_valid); end
    @(negedge clk);
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL drain_occ_c3: got %0d exp 0", occ); end
    checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL drain_valid_c3: got %b exp 00", wb_valid); end
    checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL drain_rr_ptr: got %0d exp 1", dut.rr_ptr_q); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL drain_queue: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_partial_ready();
    fu_wb_t pa [4];
    drive_slot();
    pa[2] = mk_pkt(0);
    pa[3] = mk_pkt(0);
    src_pkt[2] = pa[2];
    src_pkt[3] = pa[3];
    exp_q.push_back(pa[2]);
    exp_q.push_back(pa[3]);
    src_valid = 4'b1100;
    wb_ready = 2'b00;
    drive_slot();
    src_valid = 4'h0;
    wb_ready = 2'b01;
    @(negedge clk);
    checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL partial_valid: got %b exp 11", wb_valid); end
    checks++; if (wb_pkt[1] !== pa[3]) begin errors++; $display("FAIL partial_port1_held: got %h exp %h", wb_pkt[1], pa[3]); end
    checks++; if (src_ready !== 4'b0111) begin errors++; $display("FAIL partial_src_ready: got %b exp 0111", src_ready); end
    checks++; if (occ !== 3'd2) begin errors++; $display("FAIL partial_occ_c1: got %0d exp 2", occ); end
    @(negedge clk);
    checks++; if (dut.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL partial_rr_ptr: got %0d exp 3", dut.rr_ptr_q); end
    checks++; if (wb_valid !== 2'b01) begin errors++; $display("FAIL partial_valid_c2: got %b exp 01", wb_valid); end
    checks++; if (occ !== 3'd1) begin errors++; $display("FAIL partial_occ_c2: got %0d exp 1", occ); end
    @(negedge clk);
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL partial_occ_c3: got %0d exp 0", occ); end
    checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL partial_rr_wrap: got %0d exp 1", dut.rr_ptr_q); end
  endtask

  task automatic test_flush();
    fu_wb_t pa [4];
    drive_slot();
    pa[0] = mk_pkt(2'd1);
    pa[1] = mk_pkt(2'd2);
    pa[2] = mk_pkt(2'd1);
    pa[3] = mk_pkt(2'd2);
    for (int i = 0; i < 4; i++) src_pkt[i] = pa[i];
    src_valid = 4'hF;
    wb_ready = 2'b00;
    drive_slot();
    flush_valid = 1'b1;
    flush_epoch = 2'd2;
    wb_ready = 2'b01;
    src_valid = 4'b1000;
    src_pkt[3] = mk_pkt(2'd1);
    exp_q.push_back(pa[1]);
    exp_q.push_back(pa[3]);
    @(negedge clk);
    checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL flush_valid: got %b exp 11", wb_valid); end
    checks++; if (wb_pkt[1] !== pa[3]) begin errors++; $display("FAIL flush_port1: got %h exp %h", wb_pkt[1], pa[3]); end
    checks++; if (src_ready[3] !== 1'b1) begin errors++; $display("FAIL flush_stale_in_ready: got %b exp 1", src_ready[3]); end
    checks++; if (occ !== 3'd4) begin errors++; $display("FAIL flush_occ_before: got %0d exp 4", occ); end
    drive_slot();
    flush_valid = 1'b0;
    src_valid = 4'h0;
    wb_ready = 2'b11;
    @(negedge clk);
    checks++; if (occ !== 3'd1) begin errors++; $display("FAIL flush_occ_after: got %0d exp 1", occ); end
    checks++; if (wb_valid !== 2'b01) begin errors++; $display("FAIL flush_survivor: got %b exp 01", wb_valid); end
    @(negedge clk);
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL flush_occ_end: got %0d exp 0", occ); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_queue: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    fu_wb_t p;
    wb_ready = 2'b11;
    for (int c = 0; c < 6; c++) begin
      drive_slot();
      p = mk_pkt(0);
      src_pkt[0] = p;
      src_valid = 4'b0001;
      exp_q.push_back(p);
      @(negedge clk);
      checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_c%0d: got %b exp 1", c, src_ready[0]); end
      if (c > 0) begin
        checks++; if (wb_valid !== 2'b01) begin errors++; $display("FAIL b2b_valid_c%0d: got %b exp 01", c, wb_valid); end
      end
    end
    drive_slot();
    src_valid = 4'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL b2b_occ: got %0d exp 0", occ); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    fu_wb_t p;
    drive_slot();
    p = mk_pkt(0);
    src_pkt[1] = p;
    exp_q.push_back(p);
    src_valid = 4'b0010;
    wb_ready = 2'b01;
    drive_slot();
    src_valid = 4'h0;
    drive_slot();
    for (int i = 0; i < 4; i++) src_pkt[i] = mk_pkt(0);
    src_valid = 4'hF;
    wb_ready = 2'b00;
    drive_slot();
    src_valid = 4'h0;
    @(negedge clk);
    checks++; if (occ !== 3'd4) begin errors++; $display("FAIL rstmid_occ_pre: got %0d exp 4", occ); end
    checks++; if (dut.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL rstmid_rr_pre: got %0d exp 2", dut.rr_ptr_q); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL rstmid_wb_valid: got %b exp 00", wb_valid); end
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL rstmid_occ: got %0d exp 0", occ); end
    checks++; if (src_ready !== 4'h0) begin errors++; $display("FAIL rstmid_src_ready: got %h exp 0", src_ready); end
    drive_slot();
    rst = 1'b0;
    wb_ready = 2'b11;
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL rstmid_after_valid: got %b exp 00", wb_valid); end
    checks++; if (dut.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL rstmid_rr: got %0d exp 1", dut.rr_ptr_q); end
    wb_ready = 2'b00;
  endtask

  task automatic test_rr_wrap();
    fu_wb_t q1, q2, q3;
    drive_slot();
    q2 = mk_pkt(0);
    b_src_pkt[2] = q2;
    exp_q_b.push_back(q2);
    b_src_valid = 4'b0100;
    b_wb_ready = 1'b1;
    drive_slot();
    b_src_valid = 4'h0;
    @(negedge clk);
    drive_slot();
    q1 = mk_pkt(0);
    q3 = mk_pkt(0);
    b_src_pkt[1] = q1;
    b_src_pkt[3] = q3;
    exp_q_b.push_back(q3);
    exp_q_b.push_back(q1);
    b_src_valid = 4'b1010;
    b_wb_ready = 1'b0;
    drive_slot();
    b_src_valid = 4'h0;
    b_wb_ready = 1'b1;
    @(negedge clk);
    checks++; if (dut_b.rr_ptr_q !== 2'd3) begin errors++; $display("FAIL rr_ptr_start: got %0d exp 3", dut_b.rr_ptr_q); end
    checks++; if (b_wb_pkt[0] !== q3) begin errors++; $display("FAIL rr_first_src3: got %h exp %h", b_wb_pkt[0], q3); end
    checks++; if (b_occ !== 3'd2) begin errors++; $display("FAIL rr_occ: got %0d exp 2", b_occ); end
    @(negedge clk);
    checks++; if (dut_b.rr_ptr_q !== 2'd1) begin errors++; $display("FAIL rr_ptr_wrap: got %0d exp 1", dut_b.rr_ptr_q); end
    checks++; if (b_wb_pkt[0] !== q1) begin errors++; $display("FAIL rr_second_src1: got %h exp %h", b_wb_pkt[0], q1); end
    @(negedge clk);
    checks++; if (dut_b.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL rr_ptr_end: got %0d exp 2", dut_b.rr_ptr_q); end
    checks++; if (b_occ !== 3'd0) begin errors++; $display("FAIL rr_occ_end: got %0d exp 0", b_occ); end
  endtask

  task automatic test_starve();
    fu_wb_t s0 [5];
    fu_wb_t s3, exp5;
    for (int c = 0; c < 5; c++) s0[c] = mk_pkt(0);
    s3 = mk_pkt(0);
    for (int c = 0; c < 4; c++) exp_q_b.push_back(s0[c]);
`ifdef CDB_STARVE_EN
    exp_q_b.push_back(s3);
    exp_q_b.push_back(s0[4]);
    exp5 = s3;
`else
    exp_q_b.push_back(s0[4]);
    exp_q_b.push_back(s3);
    exp5 = s0[4];
`endif
    drive_slot();
    b_src_pkt[0] = s0[0];
    b_src_pkt[3] = s3;
    b_src_valid = 4'b1001;
    b_wb_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      drive_slot();
      if (c <= 4) begin
        b_src_valid = 4'b0001;
        b_src_pkt[0] = s0[c];
      end else begin
        b_src_valid = 4'h0;
      end
      @(negedge clk);
      checks++; if (b_wb_valid !== 1'b1) begin errors++; $display("FAIL starve_valid_c%0d: got %b exp 1", c, b_wb_valid); end
      if (c < 5) begin
        checks++; if (b_wb_pkt[0] !== s0[c-1]) begin errors++; $display("FAIL starve_src0_c%0d: got %h exp %h", c, b_wb_pkt[0], s0[c-1]); end
      end else begin
        checks++; if (b_wb_pkt[0] !== exp5) begin errors++; $display("FAIL starve_c5_winner: got %h exp %h", b_wb_pkt[0], exp5); end
      end
      if (c == 4) begin
        checks++; if (b_src_ready[3] !== 1'b0) begin errors++; $display("FAIL starve_src3_blocked: got %b exp 0", b_src_ready[3]); end
      end
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (b_occ !== 3'd0) begin errors++; $display("FAIL starve_occ_end: got %0d exp 0", b_occ); end
    checks++; if (exp_q_b.size() != 0) begin errors++; $display("FAIL starve_queue: got %0d left exp 0", exp_q_b.size()); end
  endtask

  initial begin
    src_valid     = '0;
    src_pkt       = '0;
    flush_valid   = 1'b0;
    flush_epoch   = '0;
    wb_ready      = '0;
    b_src_valid   = '0;
    b_src_pkt     = '0;
    b_flush_valid = 1'b0;
    b_flush_epoch = '0;
    b_wb_ready    = '0;

    test_reset();
    test_drain_all();
    test_partial_ready();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_rr_wrap();
    test_starve();

    checks++;
    if (exp_q.size() != 0 || exp_q_b.size() != 0) begin
      errors++;
      $display("FAIL final_queues: got %0d/%0d left exp 0/0", exp_q.size(), exp_q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
